// File: rtl/adc_capture_sequencer.sv
// Arms on request, waits for a selected trigger, then gates exactly capture_len beats
// from each ADC stream to its buffer. Optional m_axis_tlast output: ADC_CAPTURE_TLAST_EN.
module adc_capture_sequencer #(
  parameter int unsigned NCHAN     = 4,
  parameter int unsigned ADC_WIDTH = 128,
  parameter int unsigned LEN_BITS  = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       sw_trig,
  input  logic                       sysref,
  input  logic [1:0]                 trig_sel,
  input  logic [LEN_BITS-1:0]        capture_len,
  input  logic [NCHAN*ADC_WIDTH-1:0] s_axis_tdata,
  input  logic [NCHAN-1:0]           s_axis_tvalid,
  output logic [NCHAN-1:0]           s_axis_tready,
  output logic [NCHAN*ADC_WIDTH-1:0] m_axis_tdata,
  output logic [NCHAN-1:0]           m_axis_tvalid,
  input  logic [NCHAN-1:0]           m_axis_tready,
`ifdef ADC_CAPTURE_TLAST_EN
  output logic [NCHAN-1:0]           m_axis_tlast,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [LEN_BITS-1:0]        beat_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;
  typedef enum logic [1:0] {TRIG_SW, TRIG_SYSREF, TRIG_IMM, TRIG_NONE} trig_e;

  state_e                     state_q, state_d;
  trig_e                      trig_sel_q, trig_sel_d;
  logic [LEN_BITS-1:0]        len_q, len_d;
  logic [LEN_BITS-1:0]        beat_count_q, beat_count_d;
  logic                       overflow_q, overflow_d;
  logic                       sysref_d_q;
  logic [NCHAN*ADC_WIDTH-1:0] tdata_q;
  logic [NCHAN-1:0]           tvalid_q, tvalid_d;
  logic                       trig_fire;
  logic                       last_beat;
`ifdef ADC_CAPTURE_TLAST_EN
  logic [NCHAN-1:0]           tlast_q, tlast_d;
`endif

  always_comb begin
    trig_fire = 1'b0;
    case (trig_sel_q)
      TRIG_SW:     trig_fire = sw_trig;
      TRIG_SYSREF: trig_fire = sysref & ~sysref_d_q;
      TRIG_IMM:    trig_fire = 1'b1;
      default:     trig_fire = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    trig_sel_d   = trig_sel_q;
    len_d        = len_q;
    beat_count_d = beat_count_q;
    overflow_d   = overflow_q | (|(tvalid_q & ~m_axis_tready));
    last_beat    = 1'b0;
    // Abort outranks arm, trigger and beat completion, so it is decoded first.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            trig_sel_d   = trig_e'(trig_sel);
            len_d        = capture_len;
            beat_count_d = '0;
            overflow_d   = 1'b0;
            state_d      = (capture_len == '0) ? S_DONE : S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_fire) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (s_axis_tvalid[0]) begin
            beat_count_d = beat_count_q + LEN_BITS'(1);
            if (beat_count_q == len_q - LEN_BITS'(1)) begin
              last_beat = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tvalid_d = s_axis_tvalid & {NCHAN{(state_q == S_CAPTURE) && !abort}};
`ifdef ADC_CAPTURE_TLAST_EN
    tlast_d  = tvalid_d & {NCHAN{last_beat}};
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      trig_sel_q   <= TRIG_SW;
      len_q        <= '0;
      beat_count_q <= '0;
      overflow_q   <= 1'b0;
      sysref_d_q   <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= '0;
`ifdef ADC_CAPTURE_TLAST_EN
      tlast_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      trig_sel_q   <= trig_sel_d;
      len_q        <= len_d;
      beat_count_q <= beat_count_d;
      overflow_q   <= overflow_d;
      sysref_d_q   <= sysref;
      tdata_q      <= s_axis_tdata;
      tvalid_q     <= tvalid_d;
`ifdef ADC_CAPTURE_TLAST_EN
      tlast_q      <= tlast_d;
`endif
    end
  end

  assign s_axis_tready = '1;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
`ifdef ADC_CAPTURE_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`endif
  assign busy          = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done          = (state_q == S_DONE);
  assign overflow      = overflow_q;
  assign beat_count    = beat_count_q;

endmodule
